// File: rtl/wb_pcm_mixer_pkg.sv
// Shared definitions for the Wishbone PCM streamer/mixer: register map,
// STATUS/CTRL bit positions, unity volume and the 16-bit saturator.
package pcm_mixer_pkg;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_CTRL   = 3'd1,
        REG_STATUS = 3'd2,
        REG_RATE   = 3'd3,
        REG_VOL    = 3'd4
    } reg_idx_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int ST_EMPTY_BIT    = 16;
    localparam int ST_FULL_BIT     = 17;
    localparam int ST_UNDERRUN_BIT = 18;
    localparam int ST_OVERFLOW_BIT = 19;

    localparam logic [8:0] VOL_UNITY = 9'd256;

    // Clamp an 18-bit signed sum into the signed 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] s);
        logic signed [15:0] r;
        if (s > 18'sd32767) begin
            r = 16'sh7FFF;
        end else if (s < -18'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = s[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_pcm_mixer_fifo.sv
// Synchronous FIFO for PCM samples; clear has priority over push and pop,
// and a push into a full FIFO is accepted only if a pop frees a slot that cycle.
module pcm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (clr) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (level_r != LVL_ZERO);
            do_push_s = push && ((level_r != FULL_LVL) || do_pop_s);
        end
    end

    // Sample storage, left without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (clr) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (level_r == FULL_LVL);
    assign empty = (level_r == LVL_ZERO);
    assign level = level_r;

endmodule

// File: rtl/wb_pcm_mixer.sv
// Wishbone PCM sample streamer: FIFO-fed PCM played at a programmable rate,
// scaled and mixed with the PSG sound into a saturated 16-bit sample.
module wb_pcm_mixer
    import pcm_mixer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 256,
    parameter int          CLK_HZ     = 50000000,
    parameter logic [15:0] RATE_RESET = 16'd1133
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    output logic        wb_stall,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic        wb_ack,
    input  logic        wb_we,
    output logic        wb_err,
    input  logic [15:0] psg_in,
    output logic [15:0] mix_out,
    output logic        irq
);

    localparam int             LW            = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]  HALF_LVL      = LW'(FIFO_DEPTH / 2);
    localparam int             unused_clk_hz = CLK_HZ;

    logic               req_s, wr_s, w1c_s;
    logic               push_s, clr_s, tick_s, pop_s;
    logic               underrun_set_s, overflow_set_s;
    logic [15:0]        rate_eff_s;
    logic [31:0]        rdata_s;
    logic [15:0]        fifo_dout_s;
    logic               full_s, empty_s;
    logic [LW-1:0]      level_s;
    logic signed [25:0] pcm_prod_s, psg_prod_s;
    logic signed [17:0] sum_s;
    logic               unused_s;

    logic               ack_r;
    logic [31:0]        rdata_r;
    logic               en_r, underrun_r, overflow_r, irq_r;
    logic [15:0]        rate_r, cnt_r;
    logic [8:0]         pcm_vol_r, psg_vol_r;
    logic signed [15:0] pcm_cur_r, mix_r;
    logic signed [16:0] p_r, q_r;

    assign unused_s = ^{wb_sel, wb_dat_w[31:25]};

    // Decode bus requests and the timer tick.
    always_comb begin
        req_s          = wb_cyc & wb_stb;
        wr_s           = req_s & wb_we;
        push_s         = wr_s && (wb_adr == REG_DATA);
        clr_s          = wr_s && (wb_adr == REG_CTRL) && wb_dat_w[CTRL_CLR_BIT];
        w1c_s          = wr_s && (wb_adr == REG_STATUS);
        tick_s         = en_r && (cnt_r == 16'd0);
        pop_s          = tick_s && !empty_s && !clr_s;
        underrun_set_s = tick_s && empty_s;
        overflow_set_s = push_s && !clr_s && full_s && !pop_s;
        rate_eff_s     = (rate_r == 16'd0) ? 16'd1 : rate_r;
    end

    // Read-back mux.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_idx_e'(wb_adr))
            REG_CTRL:   rdata_s = {31'd0, en_r};
            REG_STATUS: rdata_s = {12'd0, overflow_r, underrun_r, full_s, empty_s,
                                   5'd0, 11'(level_s)};
            REG_RATE:   rdata_s = {16'd0, rate_r};
            REG_VOL:    rdata_s = {7'd0, psg_vol_r, 7'd0, pcm_vol_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Single-cycle acknowledge; read data is only non-zero alongside ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= req_s;
            rdata_r <= (req_s && !wb_we) ? rdata_s : 32'd0;
        end
    end

    // Writable control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r      <= 1'b0;
            rate_r    <= RATE_RESET;
            pcm_vol_r <= VOL_UNITY;
            psg_vol_r <= VOL_UNITY;
        end else if (wr_s) begin
            case (reg_idx_e'(wb_adr))
                REG_CTRL: en_r <= wb_dat_w[CTRL_EN_BIT];
                REG_RATE: rate_r <= wb_dat_w[15:0];
                REG_VOL: begin
                    pcm_vol_r <= wb_dat_w[8:0];
                    psg_vol_r <= wb_dat_w[24:16];
                end
                default: en_r <= en_r;
            endcase
        end
    end

    // Sticky error flags; a hardware set beats a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (w1c_s && wb_dat_w[ST_UNDERRUN_BIT]) begin
                underrun_r <= 1'b0;
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (w1c_s && wb_dat_w[ST_OVERFLOW_BIT]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Sample timer: held at RATE while disabled, so enabling starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= 16'd0;
            pcm_cur_r <= 16'sd0;
        end else if (!en_r) begin
            cnt_r     <= rate_eff_s;
            pcm_cur_r <= 16'sd0;
        end else if (tick_s) begin
            cnt_r     <= rate_eff_s;
            pcm_cur_r <= pop_s ? fifo_dout_s : 16'sd0;
        end else begin
            cnt_r     <= cnt_r - 16'd1;
            pcm_cur_r <= clr_s ? 16'sd0 : pcm_cur_r;
        end
    end

    pcm_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .clr   (clr_s),
        .din   (wb_dat_w[15:0]),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    // Volume scaling with the zero-extended volume kept non-negative.
    always_comb begin
        pcm_prod_s = pcm_cur_r * $signed({1'b0, pcm_vol_r});
        psg_prod_s = $signed(psg_in) * $signed({1'b0, psg_vol_r});
        sum_s      = $signed({p_r[16], p_r}) + $signed({q_r[16], q_r});
    end

    // Two-stage mix pipeline and the registered FIFO-level interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r   <= 17'sd0;
            q_r   <= 17'sd0;
            mix_r <= 16'sd0;
            irq_r <= 1'b0;
        end else begin
            p_r   <= 17'(pcm_prod_s >>> 8);
            q_r   <= 17'(psg_prod_s >>> 8);
            mix_r <= sat16(sum_s);
            irq_r <= en_r && (level_s <= HALF_LVL);
        end
    end

    assign wb_ack   = ack_r;
    assign wb_dat_r = rdata_r;
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;
    assign mix_out  = mix_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_wb_pcm_mixer.sv
// Directed bench for wb_pcm_mixer: register reset values, playback timing,
// saturation, volume scaling, FIFO overflow/clear and asynchronous reset.
module tb_wb_pcm_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wb_adr = 3'd0;
    logic [31:0] wb_dat_w = 32'd0;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_stall;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic        wb_we = 1'b0;
    logic        wb_err;
    logic [15:0] psg_in = 16'd0;
    logic [15:0] mix_out;
    logic        irq;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] rd;

    wb_pcm_mixer dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_dat_r (wb_dat_r),
        .wb_sel   (wb_sel),
        .wb_stall (wb_stall),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_ack   (wb_ack),
        .wb_we    (wb_we),
        .wb_err   (wb_err),
        .psg_in   (psg_in),
        .mix_out  (mix_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat);
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_w = dat;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat);
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
        @(posedge clk);
        #1;
        dat = wb_dat_r;
        if (wb_ack !== 1'b1) begin
            failed++;
            total++;
            $error("FAIL read_ack: observed %b expected 1", wb_ack);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < n; i++) begin
            wb_write(3'd0, {16'd0, 16'(base + 16'(i) * step)});
        end
    endtask

    initial begin
        // Reset values
        cycles(3);
        check("rst_mix", {16'd0, mix_out}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_ack", {31'd0, wb_ack}, 32'h0);
        check("rst_datr", wb_dat_r, 32'h0);
        rst = 1'b0;
        wb_read(3'd2, rd); check("rst_status", rd, 32'h0001_0000);
        wb_read(3'd3, rd); check("rst_rate", rd, 32'd1133);
        wb_read(3'd4, rd); check("rst_vol", rd, 32'h0100_0100);
        wb_read(3'd1, rd); check("rst_ctrl", rd, 32'h0);
        check("idle_datr", wb_dat_r, 32'h0);
        wb_write(3'd5, 32'hDEAD_BEEF);
        wb_read(3'd5, rd); check("unmapped", rd, 32'h0);

        // Playback: three samples then an underrun
        wb_write(3'd3, 32'd9);
        wb_write(3'd0, 32'h0000_1000);
        wb_write(3'd0, 32'h0000_2000);
        wb_write(3'd0, 32'h0000_7FFF);
        wb_read(3'd0, rd); check("data_read", rd, 32'h0);
        wb_read(3'd2, rd); check("level3", rd, 32'h0000_0003);
        check("irq_dis", {31'd0, irq}, 32'h0);
        wb_write(3'd1, 32'h1);
        cycles(11); check("pre_tick1", {16'd0, mix_out}, 32'h0);
        cycles(1);  check("tick1", {16'd0, mix_out}, 32'h1000);
        check("irq_en", {31'd0, irq}, 32'h1);
        cycles(9);  check("hold1", {16'd0, mix_out}, 32'h1000);
        cycles(1);  check("tick2", {16'd0, mix_out}, 32'h2000);
        cycles(10); check("tick3", {16'd0, mix_out}, 32'h7FFF);
        cycles(10); check("tick4_zero", {16'd0, mix_out}, 32'h0);
        wb_read(3'd2, rd); check("underrun", rd, 32'h0005_0000);
        wb_write(3'd1, 32'h0);
        wb_write(3'd2, 32'h000C_0000);
        wb_read(3'd2, rd); check("w1c_underrun", rd, 32'h0001_0000);
        check("irq_off", {31'd0, irq}, 32'h0);

        // Saturation
        psg_in = 16'h7000;
        cycles(3); check("psg_only", {16'd0, mix_out}, 32'h7000);
        wb_write(3'd0, 32'h0000_7000);
        wb_write(3'd1, 32'h1);
        cycles(12); check("sat_pos", {16'd0, mix_out}, 32'h7FFF);
        wb_write(3'd1, 32'h0);
        psg_in = 16'h9000;
        wb_write(3'd0, 32'h0000_9000);
        cycles(3); check("psg_neg", {16'd0, mix_out}, 32'h9000);
        wb_write(3'd1, 32'h1);
        cycles(12); check("sat_neg", {16'd0, mix_out}, 32'h8000);
        wb_write(3'd1, 32'h0);

        // Volume scaling
        wb_write(3'd4, 32'h0080_0080);
        psg_in = 16'h8001;
        cycles(3); check("psg_half_neg", {16'd0, mix_out}, 32'hC000);
        psg_in = 16'h0000;
        wb_write(3'd0, 32'h0000_4000);
        wb_write(3'd1, 32'h1);
        cycles(12); check("pcm_half", {16'd0, mix_out}, 32'h2000);
        wb_write(3'd1, 32'h0);
        wb_write(3'd4, 32'h0000_0100);
        wb_read(3'd4, rd); check("vol_rb", rd, 32'h0000_0100);
        psg_in = 16'h7FFF;
        cycles(3); check("psg_mute", {16'd0, mix_out}, 32'h0);
        wb_write(3'd4, 32'h0100_0100);
        psg_in = 16'h0000;

        // Overflow and clear
        push_n(257, 16'h0010, 16'h0001);
        wb_read(3'd2, rd); check("full_ovf", rd, 32'h000A_0100);
        check("irq_full_dis", {31'd0, irq}, 32'h0);
        wb_write(3'd1, 32'h2);
        wb_read(3'd2, rd); check("clr", rd, 32'h0009_0000);
        wb_read(3'd1, rd); check("ctrl_clr_rd", rd, 32'h0);
        wb_write(3'd2, 32'h0008_0000);
        wb_read(3'd2, rd); check("w1c_ovf", rd, 32'h0001_0000);

        // Half-full threshold, then asynchronous reset mid-playback
        push_n(129, 16'h0100, 16'h0000);
        psg_in = 16'h1234;
        wb_write(3'd1, 32'h1);
        cycles(3); check("irq_129", {31'd0, irq}, 32'h0);
        cycles(9);
        check("irq_128", {31'd0, irq}, 32'h1);
        check("mix_play", {16'd0, mix_out}, 32'h1334);
        rst = 1'b1;
        #1;
        check("async_mix", {16'd0, mix_out}, 32'h0);
        check("async_irq", {31'd0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_read(3'd2, rd); check("post_status", rd, 32'h0001_0000);
        wb_read(3'd1, rd); check("post_ctrl", rd, 32'h0);
        wb_read(3'd3, rd); check("post_rate", rd, 32'd1133);
        check("post_irq", {31'd0, irq}, 32'h0);
        check("post_psg", {16'd0, mix_out}, 32'h1234);
        wb_write(3'd1, 32'h1);
        cycles(2); check("irq_empty_en", {31'd0, irq}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
